// File: rtl/crypto_bus_pkg.sv
// Shared definitions for the crypto interconnect data-bus arbiter:
// source IDs, source count and the arbiter state encoding.
package crypto_bus_pkg;

  localparam int N_SRC    = 4;
  localparam int SRC_ID_W = 2;

  localparam logic [SRC_ID_W-1:0] SRC_MEM  = 2'd0;
  localparam logic [SRC_ID_W-1:0] SRC_SHA  = 2'd1;
  localparam logic [SRC_ID_W-1:0] SRC_AES  = 2'd2;
  localparam logic [SRC_ID_W-1:0] SRC_CTRL = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/crypto_bus_arbiter_rr_pick4.sv
// Round-robin picker: first set request bit at or above ptr, wrapping 3 -> 0.
module rr_pick4
  import crypto_bus_pkg::*;
(
  input  logic [N_SRC-1:0]    req,
  input  logic [SRC_ID_W-1:0] ptr,
  output logic                valid,
  output logic [SRC_ID_W-1:0] id
);

  // Scan from the farthest offset down so the nearest set bit overwrites last.
  always_comb begin
    valid = 1'b0;
    id    = ptr;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[ptr + SRC_ID_W'(i)]) begin
        valid = 1'b1;
        id    = ptr + SRC_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/crypto_bus_arbiter.sv
// Round-robin bus-ownership arbiter for the four crypto interconnect sources;
// grants one owner, counts its beats and releases on last/cap/drop/timeout.
module crypto_bus_arbiter
  import crypto_bus_pkg::*;
#(
  parameter int MAX_BEATS    = 16,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    req_i,
  input  logic [N_SRC-1:0]    valid_i,
  input  logic [N_SRC-1:0]    last_i,
  output logic [N_SRC-1:0]    grant_o,
  output logic [SRC_ID_W-1:0] owner_id_o,
  output logic                bus_busy_o,
  output logic                beat_o,
  output logic [7:0]          beat_cnt_o,
  output logic                done_o,
  output logic                abort_o
);

  arb_state_t          state, state_n;
  logic [N_SRC-1:0]    grant_n;
  logic [SRC_ID_W-1:0] owner_n, rr_ptr, rr_ptr_n, pick_id;
  logic [7:0]          beat_cnt, beat_cnt_n, idle_cnt, idle_cnt_n;
  logic                done_n, abort_n, pick_valid;
  logic                beat, rel_last, rel_cap, rel_drop, rel_tmo;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rr_pick4 u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign beat       = (state == ARB_OWN) && valid_i[owner_id_o];
  assign beat_o     = beat;
  assign bus_busy_o = (state == ARB_OWN);
  assign beat_cnt_o = beat_cnt;

  // Release causes in priority order; normal ends outrank the abort causes.
  assign rel_last = beat && last_i[owner_id_o];
  assign rel_cap  = beat && (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BEATS));
  assign rel_drop = !req_i[owner_id_o];
  assign rel_tmo  = !beat && (({1'b0, idle_cnt} + 9'd1) == 9'(IDLE_TIMEOUT));

  always_comb begin
    state_n    = state;
    grant_n    = grant_o;
    owner_n    = owner_id_o;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    idle_cnt_n = idle_cnt;
    done_n     = 1'b0;
    abort_n    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_n    = 4'b0001 << pick_id;
          owner_n    = pick_id;
          beat_cnt_n = 8'd0;
          idle_cnt_n = 8'd0;
          state_n    = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (beat) begin
          beat_cnt_n = sat_inc8(beat_cnt);
          idle_cnt_n = 8'd0;
        end else begin
          idle_cnt_n = sat_inc8(idle_cnt);
        end
        if (rel_last || rel_cap || rel_drop || rel_tmo) begin
          state_n  = ARB_RELEASE;
          grant_n  = '0;
          rr_ptr_n = owner_id_o + 2'd1;
          done_n   = rel_last || rel_cap;
          abort_n  = !(rel_last || rel_cap);
        end
      end
      ARB_RELEASE: state_n = ARB_IDLE;
      default:     state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant_o    <= '0;
      owner_id_o <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      done_o     <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      state      <= state_n;
      grant_o    <= grant_n;
      owner_id_o <= owner_n;
      rr_ptr     <= rr_ptr_n;
      beat_cnt   <= beat_cnt_n;
      idle_cnt   <= idle_cnt_n;
      done_o     <= done_n;
      abort_o    <= abort_n;
    end
  end

endmodule

// File: doc/crypto_bus_arbiter.md
# crypto_bus_arbiter

Round-robin bus-ownership arbiter for the crypto interconnect data bus, shared by the four fixed sources: MEM=0, SHA=1, AES=2, CTRL=3. It sits alongside the ACK bus in the interconnect top. It grants exclusive bus ownership to one source at a time and counts that source's data beats. It releases the bus on a last beat, a burst-length cap, a dropped request, or an idle timeout.

## Interface
- `MAX_BEATS`, default 16: burst cap; ownership ends after this many accepted beats (range 1..255).
- `IDLE_TIMEOUT`, default 32: consecutive owner cycles with no beat before forced release (range 1..255).
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 4: bus request per source, indexed by source ID.
- `valid_i` in 4: data-beat valid per source; only the owner's bit is honoured.
- `last_i` in 4: final beat of the burst, qualified by the same source's `valid_i`.
- `grant_o` out 4: one-hot ownership; all-zero when the bus is free.
- `owner_id_o` out 2: ID of the current owner; holds the last owner while free.
- `bus_busy_o` out 1: high in the OWN state.
- `beat_o` out 1: owner beat accepted this cycle (combinational: OWN and `valid_i[owner]`).
- `beat_cnt_o` out 8: beats accepted in the current burst.
- `done_o` out 1: one-cycle pulse in RELEASE after a normal end (last beat or cap).
- `abort_o` out 1: one-cycle pulse in RELEASE after a timeout or a request drop.

## Operation
- States: IDLE, OWN, RELEASE.
- **IDLE**
  - If any `req_i` bit is set, pick the winner.
  - Winner = first set bit scanning upward from `rr_ptr`, wrapping 3→0.
  - Register the winner into `grant_o` and `owner_id_o`; clear `beat_cnt` and `idle_cnt`; go to OWN.
  - No request: stay in IDLE.
- **OWN**, evaluated each cycle with owner = `owner_id_o`:
  - Beat (`valid_i[owner]`): `beat_cnt` +1 (saturating at 255), `idle_cnt` cleared. Otherwise `idle_cnt` +1.
  - Release causes, first match wins:
    - (a) beat and `last_i[owner]`: normal.
    - (b) beat and `beat_cnt`+1 == `MAX_BEATS`: normal.
    - (c) `req_i[owner]` low: abort. Any beat in the same cycle is still counted.
    - (d) no beat and `idle_cnt`+1 == `IDLE_TIMEOUT`: abort.
  - On release go to RELEASE and set `rr_ptr` = owner+1 (mod 4).
- **RELEASE**, exactly one cycle:
  - `grant_o` = 0 and `bus_busy_o` = 0.
  - Pulse `done_o` or `abort_o` from the registered cause flag.
  - Go to IDLE.
- Non-owner `valid_i` and `last_i` are ignored.
- `last_i` without `valid_i` is ignored.
- New requests during OWN wait; there is no preemption.
- Simultaneous requests are resolved purely by `rr_ptr`. After a release, the just-served source has the lowest priority.
- `beat_cnt_o` holds its value through RELEASE and IDLE until the next grant clears it.

## Timing
- Reset values:
  - state IDLE, `grant_o` 0, `owner_id_o` 0, `rr_ptr` 0, `beat_cnt_o` 0.
  - `bus_busy_o`, `done_o` and `abort_o` all 0.
- Reset during OWN ends ownership on the next edge with no `done_o`/`abort_o` pulse.
- Request-to-grant latency: `req_i` sampled high in IDLE at edge t gives `grant_o` high after edge t.
- Bus turnaround: the release edge, then one RELEASE cycle, then IDLE. Minimum gap between two grants is 2 cycles.
- Back-to-back bursts by one requester: with `req_i` held, the source regains the bus only if no other source requests.
- `beat_o` is combinational; `grant_o`, `owner_id_o`, `done_o` and `abort_o` are registered.

## Structure
- Shared package `crypto_bus_pkg`:
  - source ID constants `SRC_MEM`, `SRC_SHA`, `SRC_AES`, `SRC_CTRL`.
  - state enum `arb_state_t`.
  - `N_SRC` = 4 and `SRC_ID_W` = 2.
- One sub-module `rr_pick4`: combinational `req[3:0]` + `ptr[1:0]` → `valid`, `id[1:0]`.
- FSM, counters and pointer live in `crypto_bus_arbiter`.

## Test plan
- **Single request.** `req_i`=0010 in IDLE → `grant_o`=0010 next cycle, `owner_id_o`=1. Then 3 beats with `last_i` on the 3rd → `beat_cnt_o`=3, `done_o` pulse, `grant_o`=0 for 1 cycle.
- **Round-robin.** All four request continuously and each sends a 1-beat burst with last. Grant order from reset is 0,1,2,3,0. The gap between successive `grant_o` assertions is exactly 2 cycles.
- **Burst cap.** `MAX_BEATS`=4, owner SHA streams `valid_i` without last → release after the 4th beat, `done_o`=1, `beat_cnt_o`=4.
- **Idle timeout.** `IDLE_TIMEOUT`=8, owner AES holds `req_i` with no valid → `abort_o` pulses in the cycle after the 8th idle OWN cycle. The next grant goes to the next requester above 2.
- **Request drop and foreign beats.** Owner CTRL drops `req_i` mid-burst → `abort_o`. Meanwhile MEM drives `valid_i`/`last_i` during CTRL ownership → no effect on `beat_cnt_o`.
- **Reset mid-burst.** `rst` asserted during OWN with `beat_cnt_o`=5 → next cycle all outputs at their reset values, no pulse; `rr_ptr`=0, so MEM wins a 4-way tie.
